biquad8_coeff_loader: RTL

//  WISHBONE initiator that bulk-loads biquad8 coefficient registers (7-bit address, 32-bit data).
//  A local table of {adr, dat} entries is filled by the control logic and then replayed, on one

---
 rtl/biquad8_coeff_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/biquad8_coeff_loader.sv
// WISHBONE initiator that replays a local {adr, coeff} table as single writes into a biquad8 target.
// Optional macro BIQUAD8_LOADER_AUTO_UPDATE_EN appends a global-update write (adr 0, dat 1).
module biquad8_coeff_loader #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 255,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          tbl_wr_i,
  input  logic [AW-1:0] tbl_adr_i,
  input  logic [24:0]   tbl_dat_i,
  input  logic [AW:0]   len_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW:0]   err_idx_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [6:0]    wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  output logic [2:0]    dbg_state_o
);

  // Bus handshake: cyc/stb/we/sel and adr/dat are held from registers for the whole
  // write; the cycle a target raises ack, err or rty terminates it, and cyc/stb drop
  // on the following cycle. err/rty beat ack when they coincide.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_NEXT  = 3'd3,
    ST_UPD   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } st_t;

`ifdef BIQUAD8_LOADER_AUTO_UPDATE_EN
  localparam st_t ST_LAST = ST_UPD;
`else
  localparam st_t ST_LAST = ST_DONE;
`endif

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);

  st_t             state_q, state_d;
  logic [AW:0]     idx_q, len_q, len_eff;
  logic [TW-1:0]   tmo_q;
  logic [6:0]      adr_q;
  logic [31:0]     dat_q;
  logic [24:0]     mem [DEPTH];
  logic            start_take, abort, acked, bus_state, term_err;

  assign len_eff   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
  assign bus_state = (state_q == ST_WRITE) || (state_q == ST_UPD);
  assign term_err  = wb_err_i | wb_rty_i;

  always_comb begin
    state_d    = state_q;
    start_take = 1'b0;
    abort      = 1'b0;
    acked      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        if (start_i) begin
          start_take = 1'b1;
          state_d    = (len_eff == '0) ? ST_LAST : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WRITE;
      ST_WRITE, ST_UPD: begin
        if (term_err) begin
          abort = 1'b1;
        end else if (wb_ack_i) begin
          acked   = 1'b1;
          state_d = (state_q == ST_WRITE) ? ST_NEXT : ST_DONE;
        end else if (tmo_q == TMO_LAST) begin
          abort = 1'b1;
        end
        if (abort) state_d = ST_ERR;
      end
      ST_NEXT: state_d = (idx_q == len_q) ? ST_LAST : ST_FETCH;
      default: state_d = ST_IDLE;
    endcase
  end

  // Table RAM: no reset, writes locked out while a replay is running.
  always_ff @(posedge wb_clk_i) begin
    if (tbl_wr_i && !busy_o) mem[tbl_adr_i] <= tbl_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      tmo_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      err_o     <= 1'b0;
      err_idx_o <= '0;
    end else begin
      state_q <= state_d;
      if (start_take) begin
        len_q     <= len_eff;
        idx_q     <= '0;
        err_o     <= 1'b0;
        err_idx_o <= '0;
      end
      // Synchronous table read lands directly in the bus output registers.
      if (state_q == ST_FETCH) begin
        adr_q <= mem[idx_q[AW-1:0]][24:18];
        dat_q <= {14'b0, mem[idx_q[AW-1:0]][17:0]};
      end
`ifdef BIQUAD8_LOADER_AUTO_UPDATE_EN
      if (state_d == ST_UPD && state_q != ST_UPD) begin
        adr_q <= 7'h00;
        dat_q <= 32'h1;
      end
`endif
      if (acked && state_q == ST_WRITE) idx_q <= idx_q + (AW+1)'(1);
      if (abort) begin
        err_o     <= 1'b1;
        err_idx_o <= idx_q;
      end
      tmo_q <= (bus_state && state_d == state_q) ? tmo_q + TW'(1) : '0;
    end
  end

  assign busy_o      = (state_q == ST_FETCH) || (state_q == ST_WRITE) ||
                       (state_q == ST_NEXT)  || (state_q == ST_UPD);
  assign done_o      = (state_q == ST_DONE);
  assign wb_cyc_o    = bus_state;
  assign wb_stb_o    = bus_state;
  assign wb_we_o     = bus_state;
  assign wb_sel_o    = {4{bus_state}};
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign dbg_state_o = state_q;

endmodule
